// File: rtl/flappy_pkg.sv
// flappy_pkg: shared scene codes, key codes, lane field offsets and LFSR step
package flappy_pkg;
  typedef enum logic [1:0] {SPLASH = 2'd0, PLAYING = 2'd1, GAMEOVER = 2'd2} scene_t;
  localparam logic [7:0] KEY_SPACE = 8'd32;
  localparam logic [7:0] KEY_R = 8'd114;
  localparam logic [7:0] KEY_X = 8'd120;
  localparam int LANE_MIN = 0;
  localparam int LANE_MAX = 1;
  localparam int LANE_POS = 2;
  localparam int LANE_FIELDS = 3;
  function automatic logic [7:0] lfsr_step(input logic [7:0] s);
    return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
  endfunction
endpackage

// File: rtl/flappy_engine_pipe_lane.sv
// pipe_lane: one scrolling pipe lane with gap reload and bird collision compare
module pipe_lane
  import flappy_pkg::*;
#(
  parameter int ALT_W = 8,
  parameter int POS_INIT = 24,
  parameter int RELOAD = 59,
  parameter int BIRD_X = 4,
  parameter int GAP_MIN = 5,
  parameter int GAP_H = 10,
  parameter int SPREAD_LOG2 = 4
) (
  input logic clk,
  input logic rst,
  input logic restart,
  input logic tick,
  input logic [7:0] rnd,
  input logic [ALT_W-1:0] alt,
  output logic [LANE_FIELDS*ALT_W-1:0] lane,
  output logic reload,
  output logic at_bird,
  output logic miss
);
  logic [ALT_W-1:0] pos, mn, mx, pos_n, mn_n, mx_n, new_min;
  assign reload = pos == '0;
  always_comb begin
    new_min = ALT_W'(GAP_MIN) + ALT_W'(rnd & 8'((1 << SPREAD_LOG2) - 1));
    pos_n = reload ? ALT_W'(RELOAD) : pos - ALT_W'(1);
    mn_n = reload ? new_min : mn;
    mx_n = reload ? new_min + ALT_W'(GAP_H) : mx;
    at_bird = pos_n == ALT_W'(BIRD_X);
    miss = alt >= mx_n || alt <= mn_n;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) {pos, mx, mn} <= {ALT_W'(POS_INIT), ALT_W'(GAP_MIN + GAP_H), ALT_W'(GAP_MIN)};
    else if (restart) {pos, mx, mn} <= {ALT_W'(POS_INIT), ALT_W'(GAP_MIN + GAP_H), ALT_W'(GAP_MIN)};
    else if (tick) {pos, mx, mn} <= {pos_n, mx_n, mn_n};
  assign lane[LANE_POS*ALT_W +: ALT_W] = pos;
  assign lane[LANE_MAX*ALT_W +: ALT_W] = mx;
  assign lane[LANE_MIN*ALT_W +: ALT_W] = mn;
endmodule

// File: rtl/flappy_engine.sv
// flappy_engine: flappy-bird game engine; define FLAPPY_SCORE_EN to enable the pipe score counter
module flappy_engine
  import flappy_pkg::*;
#(
  parameter int NUM_GAPS = 3,
  parameter int ALT_W = 8,
  parameter int TICK_DIV = 6,
  parameter int ALT_INIT = 20,
  parameter int ALT_MAX = 40,
  parameter int FLAP_V = 3,
  parameter int MAX_FALL = 3,
  parameter int BIRD_X = 4,
  parameter int PIPE_SPACING = 20,
  parameter int GAP_H = 10,
  parameter int GAP_MIN = 5,
  parameter int SPREAD_LOG2 = 4,
  parameter logic [7:0] LFSR_SEED = 8'hA5
) (
  input logic clk,
  input logic rst,
  input logic [7:0] inp,
  output logic [1:0] scene,
  output logic [ALT_W:0] bird,
  output logic [NUM_GAPS*LANE_FIELDS*ALT_W-1:0] gaps,
  output logic [15:0] score
);
  localparam int CW = $clog2(TICK_DIV + 1);
  localparam logic [7:0] SEED = LFSR_SEED == 8'd0 ? 8'd1 : LFSR_SEED;
  localparam logic signed [ALT_W:0] ONE = (ALT_W + 1)'(1);
  localparam logic signed [ALT_W:0] ZERO = (ALT_W + 1)'(0);
  localparam logic signed [ALT_W:0] FV = (ALT_W + 1)'(FLAP_V);
  localparam logic signed [ALT_W:0] MF = (ALT_W + 1)'(-MAX_FALL);
  localparam logic signed [ALT_W:0] AMAX = (ALT_W + 1)'(ALT_MAX);
  scene_t st, st_nxt;
  logic playing, start, restart, quit, tick, flap, ground, ceil, crash;
  logic [CW-1:0] cnt;
  logic [7:0] lfsr, rnd_r;
  logic [7:0] rnd [NUM_GAPS];
  logic [ALT_W-1:0] alt, alt_new;
  logic signed [ALT_W:0] vel, vel_dec, vel_new, sum;
  logic is_flapping, flap_pending;
  logic [NUM_GAPS-1:0] reload, at_bird, miss;
  always_ff @(posedge clk or posedge rst)
    if (rst) st <= SPLASH;
    else st <= st_nxt;
  always_comb
    st_nxt = st == SPLASH ? (|inp ? PLAYING : SPLASH) :
             st == PLAYING ? (quit || crash ? GAMEOVER : PLAYING) :
             st == GAMEOVER ? (inp == KEY_R ? SPLASH : GAMEOVER) : SPLASH;
  always_comb begin
    playing = st == PLAYING;
    start = st == SPLASH && |inp;
    restart = st == GAMEOVER && inp == KEY_R;
    quit = playing && inp == KEY_X;
    tick = playing && cnt == CW'(TICK_DIV - 1);
    flap = flap_pending || inp == KEY_SPACE;
  end
  assign scene = st;
  assign bird = {alt, is_flapping};
  assign crash = tick && (ground || |(at_bird & miss));
  always_comb begin
    vel_dec = vel - ONE;
    vel_new = flap ? FV : vel_dec < MF ? MF : vel_dec;
    sum = $signed({1'b0, alt}) + vel_new;
    ground = sum <= ZERO;
    ceil = sum >= AMAX;
    alt_new = ground ? '0 : ceil ? ALT_W'(ALT_MAX) : sum[ALT_W-1:0];
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) lfsr <= SEED;
    else lfsr <= lfsr_step(lfsr);
  always_ff @(posedge clk or posedge rst)
    if (rst) {alt, vel, is_flapping, flap_pending, cnt} <= {ALT_W'(ALT_INIT), ZERO, 1'b0, 1'b0, CW'(0)};
    else if (restart) {alt, vel, is_flapping, flap_pending, cnt} <= {ALT_W'(ALT_INIT), ZERO, 1'b0, 1'b0, CW'(0)};
    else if (start) cnt <= '0;
    else if (playing) begin
      cnt <= tick ? '0 : cnt + CW'(1);
      flap_pending <= !tick && flap;
      if (tick) begin
        alt <= alt_new;
        vel <= ceil ? ZERO : vel_new;
        is_flapping <= flap;
      end
    end
  always_comb begin
    rnd_r = lfsr;
    for (int i = 0; i < NUM_GAPS; i++) begin
      rnd[i] = rnd_r;
      rnd_r = reload[i] ? lfsr_step(rnd_r) : rnd_r;
    end
  end
  for (genvar i = 0; i < NUM_GAPS; i++) begin : g_lane
    pipe_lane #(
      .ALT_W(ALT_W),
      .POS_INIT(BIRD_X + (i + 1) * PIPE_SPACING),
      .RELOAD(NUM_GAPS * PIPE_SPACING - 1),
      .BIRD_X(BIRD_X),
      .GAP_MIN(GAP_MIN),
      .GAP_H(GAP_H),
      .SPREAD_LOG2(SPREAD_LOG2)
    ) u_lane (
      .clk(clk),
      .rst(rst),
      .restart(restart),
      .tick(tick),
      .rnd(rnd[i]),
      .alt(alt_new),
      .lane(gaps[(NUM_GAPS - i) * LANE_FIELDS * ALT_W - 1 -: LANE_FIELDS * ALT_W]),
      .reload(reload[i]),
      .at_bird(at_bird[i]),
      .miss(miss[i])
    );
  end
`ifdef FLAPPY_SCORE_EN
  logic [15:0] passes;
  logic [16:0] score_sum;
  always_comb begin
    passes = '0;
    for (int i = 0; i < NUM_GAPS; i++) passes = passes + 16'(at_bird[i] && !miss[i]);
    score_sum = {1'b0, score} + {1'b0, passes};
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) score <= '0;
    else if (restart) score <= '0;
    else if (tick) score <= score_sum[16] ? '1 : score_sum[15:0];
`else
  assign score = '0;
`endif
endmodule

// File: tb/tb_flappy_engine.sv
// tb_flappy_engine: directed game scenarios checked against a behavioural game model
module tb_flappy_engine;
  localparam int NG = 3;
  localparam int TD = 6;
`ifdef FLAPPY_SCORE_EN
  localparam int SCORE_ON = 1;
`else
  localparam int SCORE_ON = 0;
`endif
  localparam logic [71:0] RST_GAPS = {8'd24, 8'd15, 8'd5, 8'd44, 8'd15, 8'd5, 8'd64, 8'd15, 8'd5};
  logic clk = 0;
  logic rst;
  logic [7:0] inp;
  logic [1:0] scene;
  logic [8:0] bird;
  logic [71:0] gaps;
  logic [15:0] score;
  int errors = 0, checks = 0;
  int m_scene, m_alt, m_vel, m_flap, m_pend, m_cnt, m_score, m_lfsr;
  int m_pos [NG], m_min [NG], m_max [NG];
  int fall_alt [8] = '{19, 17, 14, 11, 8, 5, 2, 0};

  flappy_engine dut (
    .clk(clk),
    .rst(rst),
    .inp(inp),
    .scene(scene),
    .bird(bird),
    .gaps(gaps),
    .score(score)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  function automatic int lfsr_nx(input int s);
    int fb;
    fb = ((s >> 7) ^ (s >> 5) ^ (s >> 4) ^ (s >> 3)) & 1;
    return ((s << 1) | fb) & 255;
  endfunction

  task automatic model_reset(input bit full);
    m_scene = 0; m_alt = 20; m_vel = 0; m_flap = 0; m_pend = 0; m_cnt = 0; m_score = 0;
    for (int i = 0; i < NG; i++) begin
      m_pos[i] = 4 + (i + 1) * 20;
      m_min[i] = 5;
      m_max[i] = 15;
    end
    if (full) m_lfsr = 'hA5;
  endtask

  task automatic model_step(input int k);
    int nl, r, v, s;
    bit crash;
    nl = lfsr_nx(m_lfsr);
    crash = 0;
    if (m_scene == 0) begin
      if (k != 0) begin m_scene = 1; m_cnt = 0; end
    end else if (m_scene == 1) begin
      if (m_cnt == TD - 1) begin
        m_flap = (m_pend != 0 || k == 32) ? 1 : 0;
        v = m_flap ? 3 : (m_vel - 1 < -3 ? -3 : m_vel - 1);
        s = m_alt + v;
        if (s <= 0) begin m_alt = 0; crash = 1; end
        else if (s >= 40) begin m_alt = 40; v = 0; end
        else m_alt = s;
        m_vel = v; m_pend = 0; m_cnt = 0;
        r = m_lfsr;
        for (int i = 0; i < NG; i++)
          if (m_pos[i] == 0) begin
            m_pos[i] = NG * 20 - 1;
            m_min[i] = 5 + (r % 16);
            m_max[i] = m_min[i] + 10;
            r = lfsr_nx(r);
          end else m_pos[i]--;
        for (int i = 0; i < NG; i++)
          if (m_pos[i] == 4) begin
            if (m_alt >= m_max[i] || m_alt <= m_min[i]) crash = 1;
            else if (m_score + SCORE_ON <= 65535) m_score += SCORE_ON;
          end
      end else begin
        m_cnt++;
        if (k == 32) m_pend = 1;
      end
      if (k == 120 || crash) m_scene = 2;
    end else if (m_scene == 2) begin
      if (k == 114) model_reset(0);
    end else m_scene = 0;
    m_lfsr = nl;
  endtask

  function automatic logic [71:0] exp_gaps();
    logic [71:0] e = '0;
    for (int i = 0; i < NG; i++) e = {e[47:0], 8'(m_pos[i]), 8'(m_max[i]), 8'(m_min[i])};
    return e;
  endfunction

  always @(posedge clk or posedge rst)
    if (rst) model_reset(1);
    else model_step(int'(inp));

  always @(negedge clk)
    if (!rst) begin
      chk("scene", 128'(scene), 128'(m_scene));
      chk("bird", 128'(bird), 128'(m_alt * 2 + m_flap));
      chk("gaps", 128'(gaps), 128'(exp_gaps()));
      chk("score", 128'(score), 128'(m_score));
    end

  task automatic cyc(input logic [7:0] k);
    inp = k;
    @(posedge clk);
    #1;
    inp = 0;
  endtask

  initial begin
    rst = 1;
    inp = 0;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    chk("rst_scene", 128'(scene), 128'(0));
    chk("rst_bird", 128'(bird), 128'(40));
    chk("rst_gaps", 128'(gaps), 128'(RST_GAPS));
    chk("rst_score", 128'(score), 128'(0));
    repeat (10) cyc(0);
    chk("splash_hold", 128'(scene), 128'(0));
    cyc(97);
    chk("start", 128'(scene), 128'(1));
    for (int t = 0; t < 8; t++) begin
      repeat (6) cyc(0);
      chk("fall_alt", 128'(bird[8:1]), 128'(fall_alt[t]));
    end
    chk("fall_over", 128'(scene), 128'(2));
    repeat (5) cyc(32);
    cyc(97);
    chk("freeze_bird", 128'(bird), 128'(0));
    chk("freeze_scene", 128'(scene), 128'(2));
    cyc(114);
    chk("restart_scene", 128'(scene), 128'(0));
    chk("restart_bird", 128'(bird), 128'(40));
    chk("restart_gaps", 128'(gaps), 128'(RST_GAPS));
    chk("restart_score", 128'(score), 128'(0));
    cyc(97);
    repeat (2) cyc(0);
    cyc(32);
    repeat (3) cyc(0);
    chk("flap_up", 128'(bird), 128'({8'd23, 1'b1}));
    repeat (6) cyc(0);
    chk("flap_after", 128'(bird), 128'({8'd25, 1'b0}));
    cyc(120);
    chk("quit", 128'(scene), 128'(2));
    cyc(114);
    chk("quit_restart", 128'(scene), 128'(0));
    cyc(97);
    for (int t = 1; t <= 20; t++) begin
      cyc(32);
      repeat (5) cyc(0);
      if (t == 7) chk("ceil_alt", 128'(bird[8:1]), 128'(40));
      if (t == 19) chk("pre_hit_scene", 128'(scene), 128'(1));
    end
    chk("hit_scene", 128'(scene), 128'(2));
    chk("hit_pos", 128'(gaps[71:64]), 128'(4));
    chk("hit_score", 128'(score), 128'(0));
    cyc(114);
    cyc(97);
    for (int c = 0; c < 430; c++)
      cyc((m_scene == 1 && m_cnt == 2 && m_pend == 0 && m_alt < 10) ? 8'd32 : 8'd0);
    chk("survive_scene", 128'(scene), 128'(1));
    chk("survive_score", 128'(score), 128'(3 * SCORE_ON));
    chk("reload_pos", 128'(gaps[71:64]), 128'(13));
    cyc(120);
    chk("survive_quit", 128'(scene), 128'(2));
    cyc(114);
    cyc(97);
    repeat (15) cyc(0);
    chk("pre_arst_bird", 128'(bird), 128'({8'd17, 1'b0}));
    #2 rst = 1;
    #1;
    chk("arst_scene", 128'(scene), 128'(0));
    chk("arst_bird", 128'(bird), 128'(40));
    chk("arst_gaps", 128'(gaps), 128'(RST_GAPS));
    chk("arst_score", 128'(score), 128'(0));
    @(posedge clk);
    #1 rst = 0;
    repeat (3) cyc(0);
    chk("post_arst_scene", 128'(scene), 128'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
